// File: rtl/addsub_pkg.sv
// Shared definitions for the chunked add/subtract unit: FSM encoding and
// the chunk-count helper used to size the chunk index.
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int chunk_count(input int width, input int chunk);
    return width / chunk;
  endfunction

endpackage

// File: rtl/addsub_chunk.sv
// Combinational CHUNK-bit ripple-carry slice. Also reports the carry into
// its MSB so the top can form signed overflow on the final chunk.
module addsub_chunk
  import addsub_pkg::*;
#(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             cmsb
);

  logic ripple;

  // NOTE: blocking assignments here model the carry rippling bit to bit
  // within one evaluation; each output gets a value before the loop.
  always_comb begin
    ripple = cin;
    cmsb   = cin;
    sum    = '0;
    for (int i = 0; i < CHUNK; i++) begin
      if (i == CHUNK - 1) cmsb = ripple;
      sum[i] = x[i] ^ y[i] ^ ripple;
      ripple = (x[i] & y[i]) | (ripple & (x[i] ^ y[i]));
    end
    cout = ripple;
  end

endmodule

// File: rtl/addsub_chunked.sv
// Multi-cycle two's-complement adder/subtractor: processes CHUNK bits per
// cycle through one shared ripple slice, with optional signed saturation.
module addsub_chunked
  import addsub_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int CHUNK    = 4,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             subtract,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             overflow,
  output logic             carry_out
);

  localparam int NCHUNK = chunk_count(WIDTH, CHUNK);
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);
  localparam logic [WIDTH-1:0] SAT_MAX  = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_MIN  = {1'b1, {(WIDTH-1){1'b0}}};

  if (WIDTH < 2 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
    $error("addsub_chunked: WIDTH must be >= 2 and a multiple of CHUNK");
  end

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry_q;
  logic [IDX_W-1:0] idx_q;

  logic [31:0]      base;
  logic [CHUNK-1:0] slice_x;
  logic [CHUNK-1:0] slice_y;
  logic [CHUNK-1:0] slice_sum;
  logic             slice_cout;
  logic             slice_cmsb;
  logic [WIDTH-1:0] res_next;
  logic [WIDTH-1:0] out_next;
  logic             ovf_next;

  assign in_ready = (state == IDLE);
  assign base     = 32'(idx_q) * CHUNK;
  assign slice_x  = a_q[base +: CHUNK];
  assign slice_y  = b_q[base +: CHUNK];

  addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
    .x    (slice_x),
    .y    (slice_y),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout),
    .cmsb (slice_cmsb)
  );

  // NOTE: every variable is assigned a default at the top of the block so
  // no path leaves it holding its old value, which would infer a latch.
  always_comb begin
    res_next              = out;
    res_next[base +: CHUNK] = slice_sum;
    ovf_next              = slice_cmsb ^ slice_cout;
    out_next              = res_next;
    // Saturation direction follows the latched a, which shares the sign of
    // the true result whenever overflow is possible.
    if (SATURATE != 0 && ovf_next) out_next = a_q[WIDTH-1] ? SAT_MIN : SAT_MAX;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from pre-edge values. Datapath registers are reset too,
  // so nothing from an abandoned operation leaks into the next one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      carry_q   <= 1'b0;
      idx_q     <= '0;
      out       <= '0;
      overflow  <= 1'b0;
      carry_out <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b ^ {WIDTH{subtract}};
            carry_q <= subtract;
            idx_q   <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          carry_q <= slice_cout;
          idx_q   <= idx_q + 1'b1;
          if (idx_q == LAST_IDX) begin
            out       <= out_next;
            overflow  <= ovf_next;
            carry_out <= slice_cout;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            out <= res_next;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_chunked.sv
// Bench for addsub_chunked: five parameterisations driven in lockstep,
// checked against constant vectors and a signed-arithmetic reference model.
module tb_addsub_chunked;

  localparam int ND = 5;
  localparam int WS[ND] = '{8, 8, 16, 16, 16};
  localparam int CS[ND] = '{4, 4, 1, 4, 16};
  localparam int SS[ND] = '{0, 1, 0, 0, 1};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] a_i = '0;
  logic [15:0] b_i = '0;
  logic        sub_i = 1'b0;

  logic [15:0] outs [ND];
  logic        ovs  [ND];
  logic        cos  [ND];
  logic        vlds [ND];
  logic        rdys [ND];

  int nvec = 0;
  int nerr = 0;

  logic [15:0] exp_out [ND];
  logic        exp_ov  [ND];
  logic        exp_co  [ND];
  logic [15:0] act_out [ND];
  logic        act_ov  [ND];
  logic        act_co  [ND];
  int          act_lat [ND];

  always #5 clk = ~clk;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    logic [WS[g]-1:0] o;
    logic ov, co, vld, rdy;
    addsub_chunked #(.WIDTH(WS[g]), .CHUNK(CS[g]), .SATURATE(SS[g])) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (rdy),
      .a         (a_i[WS[g]-1:0]),
      .b         (b_i[WS[g]-1:0]),
      .subtract  (sub_i),
      .out_valid (vld),
      .out_ready (out_ready),
      .out       (o),
      .overflow  (ov),
      .carry_out (co)
    );
    assign outs[g] = 16'(o);
    assign ovs[g]  = ov;
    assign cos[g]  = co;
    assign vlds[g] = vld;
    assign rdys[g] = rdy;
  end

  task automatic check(input string name, input int k, input logic [31:0] act,
                       input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s dut%0d: got %h, expected %h", name, k, act, exp);
    end
  endtask

  // Reference: plain signed/unsigned integer arithmetic on the operands.
  task automatic model(input int w, input int sat, input logic [15:0] ta,
                       input logic [15:0] tb, input bit sub,
                       output logic [15:0] o, output logic ov, output logic co);
    longint m, ua, ub, sa, sb, r, smax, smin;
    m    = (longint'(1) << w) - 1;
    ua   = longint'(ta) & m;
    ub   = longint'(tb) & m;
    sa   = (ua > (m >> 1)) ? ua - (m + 1) : ua;
    sb   = (ub > (m >> 1)) ? ub - (m + 1) : ub;
    smax = m >> 1;
    smin = -(smax + 1);
    r    = sub ? sa - sb : sa + sb;
    ov   = (r > smax) || (r < smin);
    co   = sub ? (ua >= ub) : ((ua + ub) > m);
    o    = 16'(r & m);
    if (sat != 0 && ov) o = (sa >= 0) ? 16'(smax) : 16'(smin & m);
  endtask

  task automatic release_all(input bit valid_on_edge);
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = valid_on_edge;
    @(posedge clk);
    #1;
    for (int k = 0; k < ND; k++) begin
      check("out_valid_drop", k, 32'(vlds[k]), 32'd0);
      check("in_ready_back", k, 32'(rdys[k]), 32'd1);
    end
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
  endtask

  task automatic do_op(input logic [15:0] ta, input logic [15:0] tb,
                       input bit ts, input bit hold);
    bit seen [ND];
    int cyc;
    bit all_seen;
    logic [15:0] eo;
    logic eov, eco;
    @(negedge clk);
    a_i = ta; b_i = tb; sub_i = ts; in_valid = 1'b1;
    for (int k = 0; k < ND; k++) begin
      seen[k] = 1'b0;
      act_lat[k] = 0;
      check("in_ready_idle", k, 32'(rdys[k]), 32'd1);
    end
    @(posedge clk);
    cyc = 0;
    all_seen = 1'b0;
    while (!all_seen && cyc < 40) begin
      @(negedge clk);
      in_valid = 1'b0;
      a_i = 16'($urandom); b_i = 16'($urandom); sub_i = 1'($urandom);
      @(posedge clk);
      #1;
      cyc++;
      all_seen = 1'b1;
      for (int k = 0; k < ND; k++) begin
        if (!seen[k]) begin
          if (vlds[k]) begin
            seen[k] = 1'b1;
            act_lat[k] = cyc;
            act_out[k] = outs[k];
            act_ov[k]  = ovs[k];
            act_co[k]  = cos[k];
          end else begin
            all_seen = 1'b0;
          end
        end
      end
    end
    for (int k = 0; k < ND; k++) begin
      if (!seen[k]) begin
        check("timeout", k, 32'd0, 32'd1);
      end else begin
        model(WS[k], SS[k], ta, tb, ts, eo, eov, eco);
        exp_out[k] = eo; exp_ov[k] = eov; exp_co[k] = eco;
        check("out", k, 32'(act_out[k]), 32'(eo));
        check("overflow", k, 32'(act_ov[k]), 32'(eov));
        check("carry_out", k, 32'(act_co[k]), 32'(eco));
        check("latency", k, 32'(act_lat[k]), 32'(WS[k] / CS[k]));
        check("out_stable", k, 32'(outs[k]), 32'(act_out[k]));
        check("in_ready_done", k, 32'(rdys[k]), 32'd0);
      end
    end
    if (!hold) release_all(1'b0);
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    bit         sub;
    logic [7:0] o_wrap;
    bit         ov;
    bit         co;
    logic [7:0] o_sat;
  } vec_t;

  vec_t vecs [8];

  initial begin
    vecs[0] = '{8'h17, 8'h3C, 1'b0, 8'h53, 1'b0, 1'b0, 8'h53};
    vecs[1] = '{8'h64, 8'h1C, 1'b0, 8'h80, 1'b1, 1'b0, 8'h7F};
    vecs[2] = '{8'h00, 8'h80, 1'b1, 8'h80, 1'b1, 1'b0, 8'h7F};
    vecs[3] = '{8'h17, 8'hFA, 1'b1, 8'h1D, 1'b0, 1'b0, 8'h1D};
    vecs[4] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00};
    vecs[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 8'h80};
    vecs[6] = '{8'h05, 8'h05, 1'b1, 8'h00, 1'b0, 1'b1, 8'h00};
    vecs[7] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 8'h80};

    // Reset state
    #12;
    for (int k = 0; k < ND; k++) begin
      check("rst_out", k, 32'(outs[k]), 32'd0);
      check("rst_valid", k, 32'(vlds[k]), 32'd0);
      check("rst_ovf", k, 32'(ovs[k]), 32'd0);
      check("rst_co", k, 32'(cos[k]), 32'd0);
      check("rst_in_ready", k, 32'(rdys[k]), 32'd1);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors, 8-bit results compared against fixed constants
    for (int i = 0; i < 8; i++) begin
      do_op({8'h00, vecs[i].a}, {8'h00, vecs[i].b}, vecs[i].sub, 1'b0);
      check("vec_out_wrap", 0, 32'(act_out[0]), 32'(vecs[i].o_wrap));
      check("vec_ovf", 0, 32'(act_ov[0]), 32'(vecs[i].ov));
      check("vec_co", 0, 32'(act_co[0]), 32'(vecs[i].co));
      check("vec_out_sat", 1, 32'(act_out[1]), 32'(vecs[i].o_sat));
      check("vec_ovf_sat", 1, 32'(act_ov[1]), 32'(vecs[i].ov));
    end

    // Backpressure: hold DONE for 5 cycles with a stray in_valid pulse
    do_op(16'h1234, 16'h0FED, 1'b1, 1'b1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      in_valid = (c == 2);
      a_i = 16'hAAAA; b_i = 16'h5555; sub_i = 1'b0;
      @(posedge clk);
      #1;
      for (int k = 0; k < ND; k++) begin
        check("bp_out", k, 32'(outs[k]), 32'(exp_out[k]));
        check("bp_ovf", k, 32'(ovs[k]), 32'(exp_ov[k]));
        check("bp_co", k, 32'(cos[k]), 32'(exp_co[k]));
        check("bp_valid", k, 32'(vlds[k]), 32'd1);
        check("bp_in_ready", k, 32'(rdys[k]), 32'd0);
      end
    end
    // in_valid high on the release edge must not be accepted there
    release_all(1'b1);
    do_op(16'h0001, 16'h0002, 1'b0, 1'b0);

    // Reset while the 16/4 instance is at chunk 2
    @(negedge clk);
    a_i = 16'h1234; b_i = 16'h1111; sub_i = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < ND; k++) begin
      check("mid_rst_out", k, 32'(outs[k]), 32'd0);
      check("mid_rst_valid", k, 32'(vlds[k]), 32'd0);
      check("mid_rst_ovf", k, 32'(ovs[k]), 32'd0);
      check("mid_rst_co", k, 32'(cos[k]), 32'd0);
      check("mid_rst_in_ready", k, 32'(rdys[k]), 32'd1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    check("post_rst_out", 3, 32'(act_out[3]), 32'h8000);
    check("post_rst_ovf", 3, 32'(act_ov[3]), 32'd1);
    check("post_rst_lat", 3, 32'(act_lat[3]), 32'd4);

    // Random operands against the reference model
    for (int i = 0; i < 40; i++)
      do_op(16'($urandom), 16'($urandom), 1'($urandom), 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
